// File: rtl/decoder_532.sv
// decoder_532: registered 5-to-32 line decoder with active-low strobes.
// Enable gating follows the 74x138 style: sta is active-high, stb and stc
// are active-low.
// Optional feature macro: DECODER_532_SEL_OUT_EN adds sel_q (the registered
// select code) and en_q (the registered enable).
module decoder_532 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] a,
  input  logic       sta,
  input  logic       stb,
  input  logic       stc,
  output logic       c0,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic       c5,
  output logic       c6,
  output logic       c7,
  output logic       c8,
  output logic       c9,
  output logic       c10,
  output logic       c11,
  output logic       c12,
  output logic       c13,
  output logic       c14,
  output logic       c15,
  output logic       c16,
  output logic       c17,
  output logic       c18,
  output logic       c19,
  output logic       c20,
  output logic       c21,
  output logic       c22,
  output logic       c23,
  output logic       c24,
  output logic       c25,
  output logic       c26,
  output logic       c27,
  output logic       c28,
  output logic       c29,
  output logic       c30,
  output logic       c31
`ifdef DECODER_532_SEL_OUT_EN
  ,
  output logic [4:0] sel_q,
  output logic [0:0] en_q
`endif
);

  logic        w_en;
  logic [31:0] w_nextDecode;
  logic [31:0] r_outQ;

  assign w_en = sta & ~stb & ~stc;

  // Next-state decode: all strobes idle high, one pulled low when enabled.
  always_comb begin
    w_nextDecode = '1;
    if (w_en) begin
      w_nextDecode[a] = 1'b0;
    end
  end

  // Output register keeps the strobes glitch-free; reset idles them high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outQ <= '1;
    end else begin
      r_outQ <= w_nextDecode;
    end
  end

  assign {c31, c30, c29, c28, c27, c26, c25, c24,
          c23, c22, c21, c20, c19, c18, c17, c16,
          c15, c14, c13, c12, c11, c10, c9,  c8,
          c7,  c6,  c5,  c4,  c3,  c2,  c1,  c0} = r_outQ;

`ifdef DECODER_532_SEL_OUT_EN
  logic [4:0] r_selQ;
  logic       r_enQ;

  // Registered select and enable, aligned with the strobe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_selQ <= 5'd0;
      r_enQ  <= 1'b0;
    end else begin
      r_selQ <= a;
      r_enQ  <= w_en;
    end
  end

  assign sel_q   = r_selQ;
  assign en_q[0] = r_enQ;
`endif

endmodule

// File: tb/tb_decoder_532.sv
// tb_decoder_532: directed-vector bench for decoder_532 with a behavioural
// model (index of the expected low strobe) and a per-cycle compare process.
// Define DECODER_532_SEL_OUT_EN to also exercise sel_q/en_q.
`timescale 1ns/1ps
module tb_decoder_532;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] a;
  logic       sta, stb, stc;
  logic       c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14, c15;
  logic       c16, c17, c18, c19, c20, c21, c22, c23, c24, c25, c26, c27, c28, c29, c30, c31;
`ifdef DECODER_532_SEL_OUT_EN
  logic [4:0] sel_q;
  logic [0:0] en_q;
`endif

  logic [31:0] obsVec;
  int          nCompares = 0;
  int          nFail = 0;
  bit          compareOn = 1'b0;

  // Behavioural model: which strobe index must be low (-1 means none).
  int          expLow = -1;
  int          expSel = 0;
  bit          expEn  = 1'b0;

  decoder_532 dut (
    .clk(clk), .rst_n(rst_n), .a(a), .sta(sta), .stb(stb), .stc(stc),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
    .c8(c8), .c9(c9), .c10(c10), .c11(c11), .c12(c12), .c13(c13), .c14(c14), .c15(c15),
    .c16(c16), .c17(c17), .c18(c18), .c19(c19), .c20(c20), .c21(c21), .c22(c22), .c23(c23),
    .c24(c24), .c25(c25), .c26(c26), .c27(c27), .c28(c28), .c29(c29), .c30(c30), .c31(c31)
`ifdef DECODER_532_SEL_OUT_EN
    , .sel_q(sel_q), .en_q(en_q)
`endif
  );

  assign obsVec = {c31, c30, c29, c28, c27, c26, c25, c24, c23, c22, c21, c20, c19, c18, c17, c16,
                   c15, c14, c13, c12, c11, c10, c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Model update: remember what the inputs asked for at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expLow <= -1;
      expSel <= 0;
      expEn  <= 1'b0;
    end else begin
      expLow <= (sta === 1'b1 && stb === 1'b0 && stc === 1'b0) ? int'(a) : -1;
      expSel <= int'(a);
      expEn  <= (sta === 1'b1 && stb === 1'b0 && stc === 1'b0);
    end
  end

  // Per-cycle compare against the model on the falling edge.
  always @(negedge clk) begin
    if (compareOn) begin
      logic [31:0] expVec;
      for (int k = 0; k < 32; k++) expVec[k] = (k != expLow);
      nCompares++;
      if (obsVec !== expVec) begin
        nFail++;
        $display("[TB] FAIL model_strobes t=%0t got=%h want=%h", $time, obsVec, expVec);
      end
`ifdef DECODER_532_SEL_OUT_EN
      nCompares++;
      if (sel_q !== 5'(expSel) || en_q[0] !== expEn) begin
        nFail++;
        $display("[TB] FAIL model_sel_en t=%0t got sel=%0d en=%b want sel=%0d en=%b",
                 $time, sel_q, en_q, expSel, expEn);
      end
`endif
    end
  end

  task automatic applyStimulus(input logic [4:0] aIn, input logic staIn,
                               input logic stbIn, input logic stcIn);
    @(negedge clk);
    #2;
    a = aIn; sta = staIn; stb = stbIn; stc = stcIn;
  endtask

  // Wait for the capturing edge, then compare against a literal.
  task automatic checkOutput(input string name, input logic [31:0] want);
    @(posedge clk);
    #1;
    checkNow(name, want);
  endtask

  task automatic checkNow(input string name, input logic [31:0] want);
    nCompares++;
    if (obsVec !== want) begin
      nFail++;
      $display("[TB] FAIL %s got=%h want=%h", name, obsVec, want);
    end
  endtask

`ifdef DECODER_532_SEL_OUT_EN
  task automatic checkSel(input string name, input logic [4:0] wantSel, input logic wantEn);
    nCompares++;
    if (sel_q !== wantSel || en_q[0] !== wantEn) begin
      nFail++;
      $display("[TB] FAIL %s got sel=%0d en=%b want sel=%0d en=%b",
               name, sel_q, en_q, wantSel, wantEn);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b1; a = 5'd7; sta = 1'b1; stb = 1'b0; stc = 1'b0;
    #1 rst_n = 1'b0;
    #1 checkNow("reset_async_all_high", 32'hFFFF_FFFF);
    compareOn = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;
    checkOutput("after_reset_c7", 32'hFFFF_FF7F);

    // Full sweep, one code per clock; the compare process checks each cycle.
    for (int k = 0; k < 32; k++) applyStimulus(5'(k), 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkNow("sweep_end_c31", 32'h7FFF_FFFF);
    applyStimulus(5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap_c0", 32'hFFFF_FFFE);

    // Enable gating.
    applyStimulus(5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("gate_sta_low", 32'hFFFF_FFFF);
    applyStimulus(5'd5, 1'b1, 1'b1, 1'b0);
    checkOutput("gate_stb_high", 32'hFFFF_FFFF);
    applyStimulus(5'd5, 1'b1, 1'b0, 1'b1);
    checkOutput("gate_stc_high", 32'hFFFF_FFFF);
    applyStimulus(5'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("gate_restored_c5", 32'hFFFF_FFDF);

    // Latency: a change between edges must not show until the next edge.
    applyStimulus(5'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("latency_c3", 32'hFFFF_FFF7);
    applyStimulus(5'd12, 1'b1, 1'b0, 1'b0);
    #1 checkNow("latency_hold_c3", 32'hFFFF_FFF7);
    checkOutput("latency_c12", 32'hFFFF_EFFF);

    // Simultaneous enable and select change.
    applyStimulus(5'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd20, 1'b1, 1'b0, 1'b0);
    checkOutput("simul_c20", 32'hFFEF_FFFF);
    applyStimulus(5'd20, 1'b1, 1'b1, 1'b0);
    checkOutput("simul_disable", 32'hFFFF_FFFF);

`ifdef DECODER_532_SEL_OUT_EN
    applyStimulus(5'd17, 1'b1, 1'b0, 1'b0);
    checkOutput("selout_c17", 32'hFFFD_FFFF);
    checkSel("selout_en", 5'd17, 1'b1);
    applyStimulus(5'd9, 1'b0, 1'b0, 1'b0);
    checkOutput("selout_disabled", 32'hFFFF_FFFF);
    checkSel("selout_tracks", 5'd9, 1'b0);
`endif

    // Reset in the middle of operation, then resume from current inputs.
    applyStimulus(5'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("midop_c7", 32'hFFFF_FF7F);
    #2 rst_n = 1'b0;
    #1 checkNow("midop_reset_high", 32'hFFFF_FFFF);
`ifdef DECODER_532_SEL_OUT_EN
    checkSel("midop_reset_sel", 5'd0, 1'b0);
`endif
    @(posedge clk); #1;
    checkNow("midop_reset_held", 32'hFFFF_FFFF);
    @(negedge clk); #2 rst_n = 1'b1;
    checkOutput("midop_resume_c7", 32'hFFFF_FF7F);

    repeat (2) @(posedge clk);
    compareOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nCompares, nFail);
    $finish;
  end

endmodule
